// File: rtl/agg_pkg.sv
// Shared definitions for the two-channel aggregator / splitter pair.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package agg_pkg;

  // Burst controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Channel-index encoding carried in the tag bit; must match the aggregator.
  localparam logic CH1_TAG = 1'b0;
  localparam logic CH2_TAG = 1'b1;

  // Width of the per-burst word counter.
  localparam int COUNT_WIDTH = 16;

  // The tag sits directly above the payload, so its index equals the payload width.
  function automatic int tag_pos(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/agg_sync_fifo.sv
// Small synchronous FIFO with head-of-queue read from registered storage.
// Latency: a pushed word is visible at head (empty=0) the cycle after the push.
// Backpressure: push is dropped when full, pop ignored when empty; caller gates both.
module agg_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/agg_splitter.sv
// Steers a tagged aggregated stream into two independently drained output FIFOs per burst.
// Latency: accepted word appears on its channel output one cycle later; done 2 cycles after drain.
// Backpressure: ready low unless running and both FIFOs have space; outputs use valid/ready.
module agg_splitter
  import agg_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter logic [15:0] BURST_LEN  = 16'h00FF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH:0]   DATA_IN,
  input  logic                  valid,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] DATA_OUT1,
  output logic                  valid_1,
  input  logic                  ready_1,
  output logic [DATA_WIDTH-1:0] DATA_OUT2,
  output logic                  valid_2,
  input  logic                  ready_2,
  output logic                  busy,
  output logic                  done
);

  localparam int TAG_POS = tag_pos(DATA_WIDTH);

  state_t                 state;
  state_t                 state_nxt;
  logic [COUNT_WIDTH-1:0] word_cnt;
  logic                   tag;
  logic [DATA_WIDTH-1:0]  payload;
  logic                   xfer;
  logic                   last_word;
  logic                   push1;
  logic                   push2;
  logic                   pop1;
  logic                   pop2;
  logic                   full1;
  logic                   full2;
  logic                   empty1;
  logic                   empty2;

  assign tag       = DATA_IN[TAG_POS];
  assign payload   = DATA_IN[DATA_WIDTH-1:0];
  assign xfer      = valid && ready;
  assign last_word = (word_cnt == (BURST_LEN - 16'd1));
  assign push1     = xfer && (tag == CH1_TAG);
  assign push2     = xfer && (tag == CH2_TAG);

  assign valid_1 = !empty1;
  assign valid_2 = !empty2;
  assign pop1    = valid_1 && ready_1;
  assign pop2    = valid_2 && ready_2;

  agg_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .push      (push1),
    .push_data (payload),
    .pop       (pop1),
    .head      (DATA_OUT1),
    .full      (full1),
    .empty     (empty1)
  );

  agg_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo2 (
    .clk       (clk),
    .reset     (reset),
    .push      (push2),
    .push_data (payload),
    .pop       (pop2),
    .head      (DATA_OUT2),
    .full      (full2),
    .empty     (empty2)
  );

  // Burst state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus status/handshake outputs; ready depends only on registered state, never on valid.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        ready = !full1 && !full2;
        if (xfer && last_word) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (empty1 && empty2) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word counter: cleared when a burst is launched, advanced on each accepted input word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      word_cnt <= '0;
    end else if (xfer) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

endmodule
